// File: rtl/fp_wb_arbiter_if.sv
// Bus bundle between the FP result producers / decode and the write-back arbiter.
// A request from producer k transfers on a clock edge where i_req_valid[k] & o_req_ready[k]; valid, rd and data stay stable until then.
interface fp_wb_arbiter_if #(parameter int FLEN = 32);
  logic [2:0]        i_req_valid;
  logic [14:0]       i_req_rd;
  logic [3*FLEN-1:0] i_req_data;
  logic [2:0]        o_req_ready;
  logic              i_issue_valid;
  logic [4:0]        i_issue_rd;
  logic              o_issue_ready;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [4:0]        i_rs3;
  logic              o_hazard;
  logic [31:0]       o_pending;
  logic              o_rf_we;
  logic [4:0]        o_rf_rd;
  logic [FLEN-1:0]   o_rf_din;
  logic [1:0]        o_dbg_rr_ptr;

  modport master (
    output i_req_valid, i_req_rd, i_req_data, i_issue_valid, i_issue_rd,
           i_rs1, i_rs2, i_rs3,
    input  o_req_ready, o_issue_ready, o_hazard, o_pending,
           o_rf_we, o_rf_rd, o_rf_din, o_dbg_rr_ptr
  );

  modport slave (
    input  i_req_valid, i_req_rd, i_req_data, i_issue_valid, i_issue_rd,
           i_rs1, i_rs2, i_rs3,
    output o_req_ready, o_issue_ready, o_hazard, o_pending,
           o_rf_we, o_rf_rd, o_rf_din, o_dbg_rr_ptr
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// FP register-file write-back arbiter (3 producers) with pending-write scoreboard.
// Define FP_WB_RR_EN for round-robin priority; otherwise fixed priority 0 > 1 > 2.
module fp_wb_arbiter #(
  parameter int FLEN = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fp_wb_arbiter_if.slave bus
);

  logic [31:0]     pending_q, pending_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [FLEN-1:0] rf_din_q, rf_din_d;
  logic [2:0]      grant;
  logic [2:0]      accept;
  logic [4:0]      win_rd;
  logic [FLEN-1:0] win_data;
  logic            issue_ready;

`ifdef FP_WB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // ptr_q names the producer with highest priority this cycle.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      idx = wrap3({1'b0, ptr_q} + 3'(i));
      if (!found && bus.i_req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (accept[k]) ptr_d = wrap3(3'(k) + 3'd1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 2'd0;
    else          ptr_q <= ptr_d;
  end

  assign bus.o_dbg_rr_ptr = ptr_q;
`else
  always_comb begin
    grant = '0;
    if      (bus.i_req_valid[0]) grant = 3'b001;
    else if (bus.i_req_valid[1]) grant = 3'b010;
    else if (bus.i_req_valid[2]) grant = 3'b100;
  end

  assign bus.o_dbg_rr_ptr = 2'd0;
`endif

  // No grants and no issues are accepted while reset is asserted.
  assign accept          = i_rst_n ? grant : 3'b000;
  assign bus.o_req_ready = accept;

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int k = 0; k < 3; k++) begin
      if (accept[k]) begin
        win_rd   = bus.i_req_rd[5*k +: 5];
        win_data = bus.i_req_data[FLEN*k +: FLEN];
      end
    end
  end

  assign issue_ready       = i_rst_n & ~pending_q[bus.i_issue_rd];
  assign bus.o_issue_ready = issue_ready;

  // Clear before set: an untracked write to the index being issued must not cancel the new op.
  always_comb begin
    pending_d = pending_q;
    if (|accept) pending_d[win_rd] = 1'b0;
    if (bus.i_issue_valid && issue_ready) pending_d[bus.i_issue_rd] = 1'b1;
  end

  always_comb begin
    rf_we_d  = |accept;
    rf_rd_d  = rf_rd_q;
    rf_din_d = rf_din_q;
    if (|accept) begin
      rf_rd_d  = win_rd;
      rf_din_d = win_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_din_q  <= '0;
    end else begin
      pending_q <= pending_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_din_q  <= rf_din_d;
    end
  end

  assign bus.o_pending = pending_q;
  assign bus.o_hazard  = pending_q[bus.i_rs1] | pending_q[bus.i_rs2] | pending_q[bus.i_rs3];
  assign bus.o_rf_we   = rf_we_q;
  assign bus.o_rf_rd   = rf_rd_q;
  assign bus.o_rf_din  = rf_din_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: directed scenarios plus random traffic against a queue-based
// reference model; write-backs are checked by an independent monitor popping exp_q.
module tb_fp_wb_arbiter;

  localparam int FLEN = 32;

  logic i_clk;
  logic i_rst_n;

  fp_wb_arbiter_if #(.FLEN(FLEN)) bus ();

  fp_wb_arbiter #(.FLEN(FLEN)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Producer / decode drive state
  logic        p_valid [3];
  logic [4:0]  p_rd    [3];
  logic [31:0] p_data  [3];
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1, rs2, rs3;

  // Reference model state
  logic [31:0] m_pend;
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_rf_rd;
  logic [31:0] m_rf_din;
  logic [36:0] exp_q[$];

  logic [2:0]  obs_ready;
  logic        obs_issue_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < 3; k++) begin
      bus.i_req_valid[k]         = p_valid[k];
      bus.i_req_rd[5*k +: 5]     = p_rd[k];
      bus.i_req_data[32*k +: 32] = p_data[k];
    end
    bus.i_issue_valid = iss_valid;
    bus.i_issue_rd    = iss_rd;
    bus.i_rs1         = rs1;
    bus.i_rs2         = rs2;
    bus.i_rs3         = rs3;
  endtask

  task automatic model_reset();
    m_pend   = '0;
    m_ptr    = 0;
    m_we     = 1'b0;
    m_rf_rd  = '0;
    m_rf_din = '0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) p_valid[k] = 1'b0;
    iss_valid = 1'b0;
  endtask

  // Winner = first valid producer in the current priority list.
  function automatic int model_winner();
    for (int i = 0; i < 3; i++) begin
      int k;
`ifdef FP_WB_RR_EN
      k = (m_ptr + i) % 3;
`else
      k = i;
`endif
      if (p_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic check_and_model();
    int          w;
    logic [31:0] pend_before;
    logic [2:0]  exp_gnt;
    pend_before     = m_pend;
    obs_ready       = bus.o_req_ready;
    obs_issue_ready = bus.o_issue_ready;
    w = model_winner();
    exp_gnt = (w < 0) ? 3'b000 : 3'(1 << w);
    chk("rf_we",       64'(bus.o_rf_we),       64'(m_we));
    chk("rf_rd",       64'(bus.o_rf_rd),       64'(m_rf_rd));
    chk("rf_din",      64'(bus.o_rf_din),      64'(m_rf_din));
    chk("pending",     64'(bus.o_pending),     64'(m_pend));
    chk("rr_ptr",      64'(bus.o_dbg_rr_ptr),  64'(m_ptr));
    chk("req_ready",   64'(bus.o_req_ready),   64'(exp_gnt));
    chk("issue_ready", 64'(bus.o_issue_ready), 64'(!pend_before[iss_rd]));
    chk("hazard",      64'(bus.o_hazard),
        64'(pend_before[rs1] | pend_before[rs2] | pend_before[rs3]));
    m_we = 1'b0;
    if (w >= 0) begin
      exp_q.push_back({p_rd[w], p_data[w]});
      m_we        = 1'b1;
      m_rf_rd     = p_rd[w];
      m_rf_din    = p_data[w];
      m_pend[p_rd[w]] = 1'b0;
`ifdef FP_WB_RR_EN
      m_ptr = (w + 1) % 3;
`endif
      p_valid[w] = 1'b0;
    end
    if (iss_valid && !pend_before[iss_rd]) m_pend[iss_rd] = 1'b1;
  endtask

  task automatic run_cycle();
    apply();
    @(negedge i_clk);
    check_and_model();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rand_drive();
    for (int k = 0; k < 3; k++) begin
      if (!p_valid[k] && $urandom_range(0, 99) < 40) begin
        p_valid[k] = 1'b1;
        p_rd[k]    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        p_data[k]  = $urandom;
      end
    end
    iss_valid = ($urandom_range(0, 99) < 50);
    iss_rd    = 5'($urandom_range(0, 7));
    rs1       = 5'($urandom_range(0, 7));
    rs2       = 5'($urandom_range(0, 9));
    rs3       = 5'($urandom_range(0, 31));
  endtask

  function automatic logic any_valid();
    return p_valid[0] | p_valid[1] | p_valid[2];
  endfunction

  // Write-back monitor: every RF write must match the oldest predicted acceptance.
  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_rf_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d din=0x%0h with nothing expected", bus.o_rf_rd, bus.o_rf_din);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.o_rf_rd, bus.o_rf_din} !== e) begin
          n_fail++;
          $display("FAIL wb_data: got rd=%0d din=0x%0h expected rd=%0d din=0x%0h",
                   bus.o_rf_rd, bus.o_rf_din, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Producer protocol: a request not yet accepted must stay valid.
  logic [2:0] held;
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      for (int k = 0; k < 3; k++)
        assert (!(held[k] && !bus.i_req_valid[k]))
          else $error("producer %0d dropped valid before acceptance", k);
      held = bus.i_req_valid & ~bus.o_req_ready;
    end else begin
      held = 3'b000;
    end
  end

  initial begin
    logic [31:0] d0;
    for (int k = 0; k < 3; k++) begin
      p_valid[k] = 1'b0;
      p_rd[k]    = '0;
      p_data[k]  = '0;
    end
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0; rs3 = '0;
    model_reset();
    i_rst_n = 1'b0;
    held    = 3'b000;

    // While in reset: requests and issues are refused.
    p_valid[0] = 1'b1; p_valid[2] = 1'b1; iss_valid = 1'b1; iss_rd = 5'd3;
    apply();
    #2;
    chk("rst_req_ready",   64'(bus.o_req_ready),   64'(0));
    chk("rst_issue_ready", 64'(bus.o_issue_ready), 64'(0));
    chk("rst_rf_we",       64'(bus.o_rf_we),       64'(0));
    chk("rst_pending",     64'(bus.o_pending),     64'(0));
    model_reset();
    apply();
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) run_cycle();

    // Issue f5 twice, then f6.
    iss_valid = 1'b1; iss_rd = 5'd5;
    run_cycle();
    chk("t2_pend5_set", 64'(bus.o_pending[5]), 64'(1));
    run_cycle();
    chk("t2_reissue_refused", 64'(obs_issue_ready), 64'(0));
    iss_rd = 5'd6;
    run_cycle();
    chk("t2_issue6_ok", 64'(obs_issue_ready), 64'(1));
    iss_valid = 1'b0;

    // Producer 2 completes f5.
    p_valid[2] = 1'b1; p_rd[2] = 5'd5; p_data[2] = 32'h3F80_0000;
    rs1 = 5'd5; rs2 = 5'd5; rs3 = 5'd5;
    run_cycle();
    chk("t3_ready", 64'(obs_ready), 64'(3'b100));
    chk("t3_rf_we",   64'(bus.o_rf_we),      64'(1));
    chk("t3_rf_rd",   64'(bus.o_rf_rd),      64'(5));
    chk("t3_rf_din",  64'(bus.o_rf_din),     64'(32'h3F80_0000));
    chk("t3_pend5",   64'(bus.o_pending[5]), 64'(0));
    chk("t3_hazard",  64'(bus.o_hazard),     64'(0));
    run_cycle();

    // All three producers valid continuously.
    for (int k = 0; k < 3; k++) begin
      p_rd[k]   = 5'(k + 1);
      p_data[k] = $urandom;
    end
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) p_valid[k] = 1'b1;
      run_cycle();
`ifdef FP_WB_RR_EN
      chk("t4_rr_grant", 64'(obs_ready), 64'(3'(1 << (i % 3))));
`else
      chk("t4_fixed_grant", 64'(obs_ready), 64'(3'b001));
`endif
      chk("t4_we_cont", 64'(bus.o_rf_we), 64'(1));
    end
    for (int n = 0; n < 4 && any_valid(); n++) run_cycle();
    run_cycle();

    // Issue f7 while producer 1 retires pending f9.
    iss_valid = 1'b1; iss_rd = 5'd9;
    run_cycle();
    iss_rd = 5'd7;
    p_valid[1] = 1'b1; p_rd[1] = 5'd9; p_data[1] = $urandom;
    run_cycle();
    iss_valid = 1'b0;
    chk("t5_pend7", 64'(bus.o_pending[7]), 64'(1));
    chk("t5_pend9", 64'(bus.o_pending[9]), 64'(0));
    run_cycle();

    // Reset pulse while a registered write is on the RF port.
    d0 = $urandom;
    p_valid[0] = 1'b1; p_rd[0] = 5'd12; p_data[0] = d0;
    run_cycle();
    chk("t6_we_before", 64'(bus.o_rf_we), 64'(1));
`ifdef FP_WB_RR_EN
    chk("t6_ptr_before", 64'(bus.o_dbg_rr_ptr), 64'(1));
`endif
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_we",      64'(bus.o_rf_we),      64'(0));
    chk("t6_rst_pending", 64'(bus.o_pending),    64'(0));
    chk("t6_rst_ptr",     64'(bus.o_dbg_rr_ptr), 64'(0));
    chk("t6_rst_rf_rd",   64'(bus.o_rf_rd),      64'(0));
    chk("t6_rst_rf_din",  64'(bus.o_rf_din),     64'(0));
    model_reset();
    apply();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run_cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_drive();
      run_cycle();
    end
    iss_valid = 1'b0;
    for (int n = 0; n < 20 && any_valid(); n++) run_cycle();
    run_cycle();
    run_cycle();
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
